// File: rtl/aemb2_pkg.sv
// Shared definitions for the aemb2 instruction cache: state encoding and
// index/tag width helpers derived from the address and cache-size parameters.
package aemb2_pkg;

    typedef enum logic {
        ICH_FLUSH = 1'b0,
        ICH_RUN   = 1'b1
    } ich_state_t;

    function automatic int ich_idx_w(input int ich);
        return ich - 2;
    endfunction

    function automatic int ich_tag_w(input int iwb, input int ich);
        return iwb - ich;
    endfunction

endpackage

// File: rtl/aemb2_ich_ram.sv
// Single-clock line RAM for the instruction cache: one write port, one
// enabled read port with a resettable output register, write-first on collision.
module aemb2_ich_ram #(
    parameter int AW = 8,
    parameter int DW = 8
) (
    input  logic          gclk,
    input  logic          grst,
    input  logic          we,
    input  logic [AW-1:0] wadr,
    input  logic [DW-1:0] wdat,
    input  logic          re,
    input  logic [AW-1:0] radr,
    output logic [DW-1:0] rdat
);

    localparam int DEPTH = 1 << AW;

    logic [DW-1:0] mem [DEPTH];

    always_ff @(posedge gclk) begin
        if (we) mem[wadr] <= wdat;
    end

    always_ff @(posedge gclk) begin
        if (grst)
            rdat <= '0;
        else if (re)
            rdat <= (we && (wadr == radr)) ? wdat : mem[radr];
    end

endmodule

// File: rtl/aemb2_icache.sv
// Direct-mapped, one-word-per-line instruction cache with an invalidation sweep.
// Optional macro AEMB2_ICH_PARITY_EN adds an even-parity bit over {tag, data}.
//
// state     | meaning
// ICH_FLUSH | counter walks every index clearing the line; no hits reported
// ICH_RUN   | normal lookup and fill
module aemb2_icache
    import aemb2_pkg::*;
#(
    parameter int AEMB_IWB = 32,
    parameter int AEMB_ICH = 10
) (
    input  logic                gclk,
    input  logic                grst,
    input  logic                iena,
    input  logic [AEMB_IWB-1:2] ich_adr,
    input  logic                ich_fil,
    output logic                ich_hit,
    output logic [31:0]         ich_dat,
    output logic                ich_rdy,
    input  logic                ich_inv,
    input  logic                iwb_ack_i,
    input  logic [31:0]         iwb_dat_i
);

    localparam int IDX_W = ich_idx_w(AEMB_ICH);
    localparam int TAG_W = ich_tag_w(AEMB_IWB, AEMB_ICH);
`ifdef AEMB2_ICH_PARITY_EN
    localparam int PAR_W = 1;
`else
    localparam int PAR_W = 0;
`endif
    localparam int LINE_W = 1 + PAR_W + TAG_W + 32;
    localparam logic [IDX_W-1:0] CNT_LAST = {IDX_W{1'b1}};

    ich_state_t        state;
    logic [IDX_W-1:0]  cnt;
    logic [TAG_W-1:0]  tag_q;
    logic [IDX_W-1:0]  adr_idx;
    logic [TAG_W-1:0]  adr_tag;
    logic              flushing;
    logic              fill_we;
    logic              ram_we;
    logic [IDX_W-1:0]  ram_wadr;
    logic [LINE_W-1:0] fill_line;
    logic [LINE_W-1:0] ram_wdat;
    logic [LINE_W-1:0] rd_line;
    logic              rd_vld;
    logic [TAG_W-1:0]  rd_tag;
    logic              par_ok;

    assign adr_idx  = ich_adr[AEMB_ICH-1:2];
    assign adr_tag  = ich_adr[AEMB_IWB-1:AEMB_ICH];
    assign flushing = (state == ICH_FLUSH);
    assign fill_we  = ~flushing & iwb_ack_i & ich_fil;

    // The sweep owns the write port; fills arriving during it are dropped.
    assign ram_we   = ~grst & (flushing | fill_we);
    assign ram_wadr = flushing ? cnt : adr_idx;
    assign ram_wdat = flushing ? '0 : fill_line;

`ifdef AEMB2_ICH_PARITY_EN
    assign fill_line = {1'b1, ^{adr_tag, iwb_dat_i}, adr_tag, iwb_dat_i};
    assign par_ok    = ~^rd_line[LINE_W-2:0];
`else
    assign fill_line = {1'b1, adr_tag, iwb_dat_i};
    assign par_ok    = 1'b1;
`endif

    aemb2_ich_ram #(
        .AW (IDX_W),
        .DW (LINE_W)
    ) u_ram (
        .gclk (gclk),
        .grst (grst),
        .we   (ram_we),
        .wadr (ram_wadr),
        .wdat (ram_wdat),
        .re   (iena),
        .radr (adr_idx),
        .rdat (rd_line)
    );

    assign rd_vld  = rd_line[LINE_W-1];
    assign rd_tag  = rd_line[32 +: TAG_W];
    assign ich_dat = rd_line[31:0];
    assign ich_hit = ich_rdy & rd_vld & (rd_tag == tag_q) & par_ok;

    always_ff @(posedge gclk) begin
        if (grst)
            tag_q <= '0;
        else if (iena)
            tag_q <= adr_tag;
    end

    always_ff @(posedge gclk) begin
        if (grst) begin
            state   <= ICH_FLUSH;
            cnt     <= '0;
            ich_rdy <= 1'b0;
        end else if (ich_inv) begin
            state   <= ICH_FLUSH;
            cnt     <= '0;
            ich_rdy <= 1'b0;
        end else if (state == ICH_FLUSH) begin
            if (cnt == CNT_LAST) begin
                state   <= ICH_RUN;
                ich_rdy <= 1'b1;
            end else begin
                cnt <= cnt + IDX_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_aemb2_icache.sv
// Self-checking bench for aemb2_icache: a line model predicts each lookup/fill
// result into a scoreboard queue, popped and compared after the clock edge.
module tb_aemb2_icache;

    localparam int LINES = 256;

    logic        gclk = 1'b0;
    logic        grst;
    logic        iena;
    logic [31:2] ich_adr;
    logic        ich_fil;
    logic        ich_hit;
    logic [31:0] ich_dat;
    logic        ich_rdy;
    logic        ich_inv;
    logic        iwb_ack_i;
    logic [31:0] iwb_dat_i;

    always #5 gclk = ~gclk;

    aemb2_icache #(.AEMB_IWB(32), .AEMB_ICH(10)) dut (
        .gclk      (gclk),
        .grst      (grst),
        .iena      (iena),
        .ich_adr   (ich_adr),
        .ich_fil   (ich_fil),
        .ich_hit   (ich_hit),
        .ich_dat   (ich_dat),
        .ich_rdy   (ich_rdy),
        .ich_inv   (ich_inv),
        .iwb_ack_i (iwb_ack_i),
        .iwb_dat_i (iwb_dat_i)
    );

    typedef struct {
        logic        hit;
        logic [31:0] dat;
        logic        dat_vld;
    } exp_t;

    exp_t        sb[$];
    exp_t        last_exp;
    logic        m_vld [LINES];
    logic [21:0] m_tag [LINES];
    logic [31:0] m_dat [LINES];
    logic        m_rdy;
    int          n_chk = 0;
    int          n_fail = 0;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    function automatic exp_t predict(input logic [31:2] adr);
        exp_t e;
        logic [7:0] idx;
        idx       = adr[9:2];
        e.hit     = m_rdy & m_vld[idx] & (m_tag[idx] == adr[31:10]);
        e.dat     = m_dat[idx];
        e.dat_vld = m_rdy;
        return e;
    endfunction

    task automatic model_clear();
        for (int i = 0; i < LINES; i++) begin
            m_vld[i] = 1'b0;
            m_tag[i] = '0;
            m_dat[i] = '0;
        end
    endtask

    task automatic step();
        @(posedge gclk);
        @(negedge gclk);
    endtask

    task automatic compare_out(input string name);
        exp_t e;
        if (sb.size() == 0) begin
            check_val({name, "_sb_empty"}, 32'd1, 32'd0);
            return;
        end
        e = sb.pop_front();
        last_exp = e;
        check_val({name, "_hit"}, 32'(ich_hit), 32'(e.hit));
        if (e.dat_vld) check_val({name, "_dat"}, ich_dat, e.dat);
    endtask

    task automatic lookup(input logic [31:2] adr, input string name);
        ich_adr   = adr;
        iena      = 1'b1;
        ich_fil   = 1'b0;
        iwb_ack_i = 1'b0;
        sb.push_back(predict(adr));
        step();
        compare_out(name);
    endtask

    task automatic fill(input logic [31:2] adr, input logic [31:0] dat, input string name);
        ich_adr   = adr;
        iena      = 1'b1;
        ich_fil   = 1'b1;
        iwb_ack_i = 1'b1;
        iwb_dat_i = dat;
        if (m_rdy) begin
            m_vld[adr[9:2]] = 1'b1;
            m_tag[adr[9:2]] = adr[31:10];
            m_dat[adr[9:2]] = dat;
        end
        sb.push_back(predict(adr));
        step();
        ich_fil   = 1'b0;
        iwb_ack_i = 1'b0;
        compare_out(name);
    endtask

    task automatic hold(input int n);
        iena    = 1'b0;
        ich_adr = ~ich_adr;
        for (int i = 0; i < n; i++) begin
            sb.push_back(last_exp);
            step();
            compare_out("hold");
        end
    endtask

    task automatic inv_pulse();
        ich_inv = 1'b1;
        step();
        ich_inv = 1'b0;
        model_clear();
        m_rdy = 1'b0;
        check_val("inv_rdy", 32'(ich_rdy), 32'd0);
        check_val("inv_hit", 32'(ich_hit), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [31:2] radr;
        grst      = 1'b1;
        iena      = 1'b0;
        ich_adr   = '0;
        ich_fil   = 1'b0;
        ich_inv   = 1'b0;
        iwb_ack_i = 1'b0;
        iwb_dat_i = '0;
        m_rdy     = 1'b0;
        model_clear();
        repeat (3) @(negedge gclk);
        check_val("rst_rdy", 32'(ich_rdy), 32'd0);
        check_val("rst_hit", 32'(ich_hit), 32'd0);
        check_val("rst_dat", ich_dat, 32'd0);

        // Reset sweep: ich_rdy must rise on exactly the 256th edge.
        iena = 1'b1;
        grst = 1'b0;
        for (int k = 1; k <= 256; k++) begin
            step();
            check_val("sweep_rdy", 32'(ich_rdy), 32'(k == 256));
            if (k < 256 && (k % 64) == 0) check_val("sweep_hit", 32'(ich_hit), 32'd0);
        end
        m_rdy = 1'b1;

        lookup(30'h40, "cold_miss");
        fill(30'h40, 32'hB800_0010, "fill_100");
        lookup(30'h40, "hit_100");
        hold(3);

        fill(30'h140, 32'h1234_5678, "fill_500");
        lookup(30'h40, "alias_100");
        lookup(30'h140, "alias_500");

        fill(30'h7, 32'hCAFE_0007, "same_cycle_7");
        fill(30'h207, 32'h0BAD_0207, "fill_alias_7");
        lookup(30'h7, "miss_7");

        for (int i = 0; i < 24; i++) begin
            radr = {20'h0, 2'($urandom_range(0, 3)), 8'($urandom_range(0, 15))};
            if ($urandom_range(0, 1) == 1)
                fill(radr, $urandom, "rnd_fill");
            else
                lookup(radr, "rnd_look");
        end

        // Invalidate, restart at index 100, restart again at index 50.
        fill(30'h40, 32'hB800_0010, "pre_inv_fill");
        inv_pulse();
        repeat (100) step();
        inv_pulse();
        repeat (50) step();
        inv_pulse();
        for (int k = 1; k <= 256; k++) begin
            if (k == 100) begin
                ich_adr   = 30'h40;
                ich_fil   = 1'b1;
                iwb_ack_i = 1'b1;
                iwb_dat_i = 32'hDEAD_BEEF;
            end
            step();
            ich_fil   = 1'b0;
            iwb_ack_i = 1'b0;
            check_val("inv_sweep_rdy", 32'(ich_rdy), 32'(k == 256));
        end
        m_rdy = 1'b1;
        lookup(30'h40, "post_inv_miss");
        fill(30'h40, 32'hB800_0010, "post_inv_fill");
        lookup(30'h40, "post_inv_hit");

        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end

endmodule
